td4x_core: RTL and testbench
============================

# td4x_core

Parametrised successor to the fixed 4-bit TD4 processor core: a multi-cycle CPU with configurable data width and program-counter width, an explicit fetch/execute state machine, and a variable-latency req/ack instruction-memory handshake. It adds run/halt/single-step control and a registered output port with a write strobe. It sits in the mother board between the program ROM (or any memory answering the handshake) and the switch/LED I/O.

## Interface
Parameters:
- DATA_W, 4, register/immediate/IO width; must be ≥ ADDR_W
- ADDR_W, 4, program counter and instruction-memory address width

Ports:
- clk  in  1  system clock, single clock domain
- rst  in  1  asynchronous, active-high reset
- run  in  1  level; 1 = execute continuously
- step  in  1  one-cycle pulse; executes exactly one instruction while halted
- halted  out  1  1 while in IDLE
- mem_req  out  1  instruction fetch request
- mem_addr  out  ADDR_W  fetch address (= PC)
- mem_ack  in  1  fetch complete; mem_rdata valid this cycle
- mem_rdata  in  4+DATA_W  instruction: [DATA_W+3:DATA_W] opcode, [DATA_W-1:0] imm
- in_data  in  DATA_W  switch input
- out_data  out  DATA_W  registered output port
- out_we  out  1  one-cycle strobe when out_data is written
- pc_dbg  out  ADDR_W  current PC

## Operation
- State: PC, registers A and B (DATA_W), carry flag C, instruction register IR.
- Opcodes (4 bit): 0000 ADD A,imm; 0001 MOV A,B; 0010 IN A; 0011 MOV A,imm; 0100 MOV B,A; 0101 ADD B,imm; 0110 IN B; 0111 MOV B,imm; 1001 OUT B; 1011 OUT imm; 1110 JNC imm; 1111 JMP imm. All others: NOP.
- ADD: result = (reg + imm) mod 2^DATA_W; C = carry out of bit DATA_W-1. Every non-ADD instruction (including NOP, jumps) clears C.
- JMP: PC = imm[ADDR_W-1:0]. JNC: jump if C==0 (C sampled before the instruction clears it), else PC+1.
- All other instructions: PC = (PC+1) mod 2^ADDR_W; wrap from max to 0 is silent.
- OUT: out_data updated, out_we pulses.
- FSM:
  - IDLE: halted=1, mem_req=0. run=1 → FETCH. step=1 → FETCH with single-shot flag set.
  - FETCH: mem_req=1, mem_addr=PC held stable. On mem_ack: IR ← mem_rdata → EXEC.
  - EXEC: one cycle; commit registers, C, PC, output. Next: IDLE if single-shot or run=0, else FETCH. Single-shot flag cleared.
- run dropped during FETCH: handshake completes and the instruction executes; core then halts. A fetch is never abandoned except by reset.
- step while run=1 or outside IDLE: ignored.

## Timing
- Reset values: state IDLE, PC=0, A=B=0, C=0, IR=0, out_data=0, out_we=0, mem_req=0, halted=1.
- mem_ack may arrive in the first FETCH cycle (zero wait) or any later one; earliest throughput 2 cycles/instruction.
- mem_ack outside FETCH is ignored.
- Register/PC/out_data updates visible the cycle after EXEC; out_we high for exactly that one cycle.
- run rising in IDLE: mem_req high the next cycle.
- Reset asserted mid-fetch: mem_req drops asynchronously; memory must tolerate a dropped request.

## Structure
- libcpu package: opcode enum (extend existing OPECODE to full 4-bit set incl. NOP), FSM state enum, instruction field-slicing helpers parametrised by DATA_W.
- Sub-module td4x_exec: purely combinational; takes IR, A, B, C, PC, in_data; returns next A/B/C/PC, out value and out-write flag. Core holds the FSM and all flops.

## Test plan
- Reset then run=1, zero-wait memory, program MOV A,3; ADD A,2; OUT A-less OUT imm 5 → out_data=5 with one out_we pulse, A=5, PC=3 after 6 cycles.
- DATA_W=4: MOV A,15; ADD A,1; JNC 0; JMP 7 → A=0, C=1, JNC falls through, PC=7; repeat with ADD A,0 → JNC taken to 0.
- mem_ack delayed 3 cycles → mem_addr/mem_req stable throughout, IR captured on ack only; stray ack in IDLE ignored.
- Halted, step pulse → exactly one instruction executes, halted returns high after EXEC; step during run ignored.
- ADDR_W=4, PC=15 NOP → PC wraps to 0; DATA_W=8 ADD B,0xFF with B=1 → B=0, C=1.
- Reset asserted during FETCH wait → mem_req low immediately, all state at reset values.

Source files
------------

// File: rtl/td4x_pkg.sv
// rtl/td4x_pkg.sv - shared opcode/state types and decode helper for the td4x core
package td4x_pkg;

  // Full 4-bit opcode space; every encoding not listed here decodes to OP_NOP
  typedef enum logic [3:0] {
    OP_ADD_A  = 4'h0,
    OP_MOV_AB = 4'h1,
    OP_IN_A   = 4'h2,
    OP_MOV_AI = 4'h3,
    OP_MOV_BA = 4'h4,
    OP_ADD_B  = 4'h5,
    OP_IN_B   = 4'h6,
    OP_MOV_BI = 4'h7,
    OP_NOP    = 4'h8,
    OP_OUT_B  = 4'h9,
    OP_OUT_I  = 4'hB,
    OP_JNC    = 4'hE,
    OP_JMP    = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_e;

  localparam int OPC_W = 4;

  // Map a raw opcode field onto the enum, folding the unused encodings into NOP
  function automatic opcode_e decode_op(input logic [OPC_W-1:0] raw);
    case (raw)
      4'h8, 4'hA, 4'hC, 4'hD: decode_op = OP_NOP;
      default:                decode_op = opcode_e'(raw);
    endcase
  endfunction

endpackage

// File: rtl/td4x_exec.sv
// rtl/td4x_exec.sv - combinational execute stage: next A/B/C/PC and output write
module td4x_exec
  import td4x_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic [DATA_W+3:0] ir_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              c_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic              c_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] out_o,
  output logic              out_we_o
);

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  logic [DATA_W-1:0] imm;
  opcode_e           op;
  logic [DATA_W:0]   sum_a;
  logic [DATA_W:0]   sum_b;

  assign imm   = ir_i[DATA_W-1:0];
  assign op    = decode_op(ir_i[DATA_W+3:DATA_W]);
  // One extra bit on the adders captures the carry out of the MSB
  assign sum_a = {1'b0, a_i} + {1'b0, imm};
  assign sum_b = {1'b0, b_i} + {1'b0, imm};

  // Decode IR and compute the architectural state after this instruction
  always_comb begin
    a_o      = a_i;
    b_o      = b_i;
    c_o      = 1'b0;
    pc_o     = pc_i + PC_ONE;
    out_o    = b_i;
    out_we_o = 1'b0;
    case (op)
      OP_ADD_A: begin
        a_o = sum_a[DATA_W-1:0];
        c_o = sum_a[DATA_W];
      end
      OP_ADD_B: begin
        b_o = sum_b[DATA_W-1:0];
        c_o = sum_b[DATA_W];
      end
      OP_MOV_AB: a_o = b_i;
      OP_IN_A:   a_o = in_data_i;
      OP_MOV_AI: a_o = imm;
      OP_MOV_BA: b_o = a_i;
      OP_IN_B:   b_o = in_data_i;
      OP_MOV_BI: b_o = imm;
      OP_OUT_B:  out_we_o = 1'b1;
      OP_OUT_I: begin
        out_o    = imm;
        out_we_o = 1'b1;
      end
      OP_JNC: begin
        // c_i is the flag from before this instruction; c_o still clears
        if (!c_i) pc_o = imm[ADDR_W-1:0];
      end
      OP_JMP:  pc_o = imm[ADDR_W-1:0];
      default: ;
    endcase
  end

endmodule

// File: rtl/td4x_core.sv
// rtl/td4x_core.sv - multi-cycle td4x CPU: fetch/execute FSM, state registers, I/O port
module td4x_core
  import td4x_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
  output logic              halted,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W+3:0] mem_rdata,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_we,
  output logic [ADDR_W-1:0] pc_dbg
);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              c_q;
  logic [DATA_W+3:0] ir_q;
  logic [DATA_W-1:0] out_q;
  logic              out_we_q;
  logic              req_q;
  logic              halted_q;
  logic              single_q;

  logic [DATA_W-1:0] a_d;
  logic [DATA_W-1:0] b_d;
  logic              c_d;
  logic [ADDR_W-1:0] pc_d;
  logic [DATA_W-1:0] out_d;
  logic              out_wr_d;

  td4x_exec #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_exec (
    .ir_i      (ir_q),
    .a_i       (a_q),
    .b_i       (b_q),
    .c_i       (c_q),
    .pc_i      (pc_q),
    .in_data_i (in_data),
    .a_o       (a_d),
    .b_o       (b_d),
    .c_o       (c_d),
    .pc_o      (pc_d),
    .out_o     (out_d),
    .out_we_o  (out_wr_d)
  );

  assign halted   = halted_q;
  assign mem_req  = req_q;
  assign mem_addr = pc_q;
  assign out_data = out_q;
  assign out_we   = out_we_q;
  assign pc_dbg   = pc_q;

  // Fetch/execute sequencer; req/halted are registered so they change only with state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      ir_q     <= '0;
      out_q    <= '0;
      out_we_q <= 1'b0;
      req_q    <= 1'b0;
      halted_q <= 1'b1;
      single_q <= 1'b0;
    end else begin
      out_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // run has priority, so a step pulse while running is ignored
          if (run) begin
            state_q  <= ST_FETCH;
            req_q    <= 1'b1;
            halted_q <= 1'b0;
            single_q <= 1'b0;
          end else if (step) begin
            state_q  <= ST_FETCH;
            req_q    <= 1'b1;
            halted_q <= 1'b0;
            single_q <= 1'b1;
          end
        end
        ST_FETCH: begin
          // The request is held until acknowledged; it is never withdrawn here
          if (mem_ack) begin
            ir_q    <= mem_rdata;
            req_q   <= 1'b0;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          a_q      <= a_d;
          b_q      <= b_d;
          c_q      <= c_d;
          pc_q     <= pc_d;
          single_q <= 1'b0;
          if (out_wr_d) begin
            out_q    <= out_d;
            out_we_q <= 1'b1;
          end
          if (single_q || !run) begin
            state_q  <= ST_IDLE;
            halted_q <= 1'b1;
          end else begin
            state_q <= ST_FETCH;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          req_q    <= 1'b0;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_td4x_core.sv
// tb/tb_td4x_core.sv - self-checking bench for td4x_core (4-bit and 8-bit data instances)
module tb_td4x_core;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic       halted;
  logic       m_req;
  logic [3:0] m_addr;
  logic       m_ack;
  logic [7:0] m_rdata;
  logic [3:0] in_data = 4'd0;
  logic [3:0] out_data;
  logic       out_we;
  logic [3:0] pc_dbg;

  logic        run2 = 1'b0;
  logic        step2 = 1'b0;
  logic        halted2;
  logic        req2;
  logic [3:0]  addr2;
  logic        ack2;
  logic [11:0] rdata2;
  logic [7:0]  in2 = 8'd0;
  logic [7:0]  out2;
  logic        we2;
  logic [3:0]  pc2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  td4x_core #(.DATA_W(4), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .halted(halted),
    .mem_req(m_req), .mem_addr(m_addr), .mem_ack(m_ack), .mem_rdata(m_rdata),
    .in_data(in_data), .out_data(out_data), .out_we(out_we), .pc_dbg(pc_dbg)
  );

  td4x_core #(.DATA_W(8), .ADDR_W(4)) dut8 (
    .clk(clk), .rst(rst), .run(run2), .step(step2), .halted(halted2),
    .mem_req(req2), .mem_addr(addr2), .mem_ack(ack2), .mem_rdata(rdata2),
    .in_data(in2), .out_data(out2), .out_we(we2), .pc_dbg(pc2)
  );

  // Memory for the 4-bit core: programmable latency, garbage data unless acked
  logic [7:0] rom [16];
  int  cnt = 0;
  int  lat_fixed = 0;
  int  lat_rnd = 0;
  bit  rand_en = 1'b0;
  bit  stray = 1'b0;
  int  eff_lat;

  always @(posedge clk) begin
    if (!m_req) begin
      cnt     <= 0;
      lat_rnd <= $urandom_range(0, 3);
    end else begin
      cnt <= cnt + 1;
    end
  end
  assign eff_lat = rand_en ? lat_rnd : lat_fixed;
  assign m_ack   = (m_req && cnt >= eff_lat) || stray;
  assign m_rdata = m_ack ? rom[m_addr] : 8'hBF;

  logic [11:0] rom2 [16];
  assign ack2   = req2;
  assign rdata2 = rom2[addr2];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Instruction-level reference model of the 4-bit machine
  int ma, mb, mc, mpc;
  int mq[$];
  int nacc = 0;
  int nwe = 0;

  task automatic mdl_exec(input logic [7:0] ins);
    int op, imm, oldc, npc, s;
    op   = int'(ins[7:4]);
    imm  = int'(ins[3:0]);
    oldc = mc;
    npc  = (mpc + 1) % 16;
    mc   = 0;
    case (op)
      0:  begin s = ma + imm; mc = (s > 15) ? 1 : 0; ma = s % 16; end
      1:  ma = mb;
      2:  ma = int'(in_data);
      3:  ma = imm;
      4:  mb = ma;
      5:  begin s = mb + imm; mc = (s > 15) ? 1 : 0; mb = s % 16; end
      6:  mb = int'(in_data);
      7:  mb = imm;
      9:  mq.push_back(mb);
      11: mq.push_back(imm);
      14: if (oldc == 0) npc = imm;
      15: npc = imm;
      default: ;
    endcase
    mpc = npc;
  endtask

  // Scoreboard: every accepted fetch must come from the model PC; every out_we must match
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        ma = 0; mb = 0; mc = 0; mpc = 0;
        mq.delete();
        nwe = 0;
      end else begin
        if (out_we) begin
          nwe++;
          check("out_expected", (mq.size() > 0) ? 1 : 0, 1);
          if (mq.size() > 0) check("out_data", int'(out_data), mq.pop_front());
        end
        if (m_req && m_ack) begin
          nacc++;
          check("fetch_addr", int'(m_addr), mpc);
          mdl_exec(rom[mpc]);
        end
      end
    end
  end

  int nacc2 = 0;
  int nwe2 = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (req2 && ack2) nacc2++;
      if (we2) nwe2++;
    end
  end

  typedef struct {
    logic [0:15][7:0] prog;
    int lat;
    int din;
    int n;
    int exp_pc;
    int exp_out;
    int exp_nwe;
  } vec_t;

  vec_t vecs[7];

  task automatic load_prog(input logic [0:15][7:0] p);
    for (int i = 0; i < 16; i++) rom[i] = p[i];
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_halted();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (halted) begin ok = 1'b1; break; end
    end
    if (!ok) check("halt_timeout", 0, 1);
  endtask

  task automatic run_n(input int n);
    int start;
    bit ok;
    start = nacc;
    ok = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (nacc - start >= n) begin ok = 1'b1; break; end
    end
    if (!ok) check("run_timeout", nacc - start, n);
    run = 1'b0;
    wait_halted();
  endtask

  initial begin
    int start;
    bit ok;

    vecs[0] = '{128'h33_02_B5_40_90_80_80_80_80_80_80_80_80_80_80_80, 0, 0, 5, 5, 5, 2};
    vecs[1] = '{128'h3F_01_E0_F7_80_80_80_40_90_80_80_80_80_80_80_80, 3, 0, 6, 9, 0, 1};
    vecs[2] = '{128'h3F_00_E0_80_80_80_80_80_80_80_80_80_80_80_80_80, 1, 0, 4, 1, 0, 0};
    vecs[3] = '{128'h3F_01_40_E6_80_80_B5_80_80_80_80_80_80_80_80_80, 2, 0, 5, 7, 5, 1};
    vecs[4] = '{128'h20_40_90_71_60_90_80_80_80_80_80_80_80_80_80_80, 0, 9, 6, 6, 9, 2};
    vecs[5] = '{128'hFF_80_80_80_80_80_80_80_80_80_80_80_80_80_80_A3, 2, 0, 2, 0, 0, 0};
    vecs[6] = '{128'h71_5F_10_E8_80_80_80_80_B3_80_80_80_80_80_80_80, 1, 0, 5, 9, 3, 1};

    for (int i = 0; i < 16; i++) rom2[i] = 12'h800;
    rom2[0] = 12'h701; rom2[1] = 12'h5FF; rom2[2] = 12'hE05;
    rom2[3] = 12'h900; rom2[5] = 12'hBAA;

    // Reset values
    load_prog(vecs[0].prog);
    do_reset();
    check("rst_halted", int'(halted), 1);
    check("rst_mem_req", int'(m_req), 0);
    check("rst_pc", int'(pc_dbg), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_we", int'(out_we), 0);

    // Ack delayed by 3 cycles: request and address held, IR taken on ack only
    lat_fixed = 3;
    start = nacc;
    run = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check("wait_req", int'(m_req), 1);
      check("wait_addr", int'(m_addr), 0);
    end
    check("wait_no_accept", nacc - start, 0);
    @(negedge clk); #1;
    check("ack_accept", nacc - start, 1);
    run = 1'b0;
    wait_halted();
    check("ack_pc", int'(pc_dbg), 1);
    check("ack_nwe", nwe, 0);

    // Stray ack while idle is ignored
    stray = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check("stray_halted", int'(halted), 1);
      check("stray_req", int'(m_req), 0);
    end
    stray = 1'b0;
    @(negedge clk); #1;
    check("stray_pc", int'(pc_dbg), 1);

    // Single step: exactly one instruction per pulse
    lat_fixed = 0;
    for (int s = 0; s < 2; s++) begin
      start = nacc;
      step = 1'b1;
      @(negedge clk); #1;
      step = 1'b0;
      wait_halted();
      check("step_count", nacc - start, 1);
      check("step_pc", int'(pc_dbg), 2 + s);
    end
    check("step_nwe", nwe, 1);
    check("step_out", int'(out_data), 5);

    // Step while running is ignored: core keeps running
    run = 1'b1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    step = 1'b1;
    @(negedge clk); #1;
    step = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("step_in_run_halted", int'(halted), 0);
    run = 1'b0;
    wait_halted();

    // Directed programs
    foreach (vecs[v]) begin
      load_prog(vecs[v].prog);
      lat_fixed = vecs[v].lat;
      in_data = 4'(vecs[v].din);
      do_reset();
      run_n(vecs[v].n);
      check($sformatf("vec%0d_pc", v), int'(pc_dbg), vecs[v].exp_pc);
      check($sformatf("vec%0d_out", v), int'(out_data), vecs[v].exp_out);
      check($sformatf("vec%0d_nwe", v), nwe, vecs[v].exp_nwe);
    end

    // Reset during a fetch wait drops the request at once
    lat_fixed = 10;
    run = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("midfetch_req", int'(m_req), 1);
    rst = 1'b1;
    #1;
    check("midfetch_rst_req", int'(m_req), 0);
    check("midfetch_rst_halted", int'(halted), 1);
    check("midfetch_rst_pc", int'(pc_dbg), 0);
    check("midfetch_rst_out", int'(out_data), 0);
    run = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    rst = 1'b0;

    // Random programs, random latency, checked by the model
    rand_en = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
      in_data = 4'($urandom);
      do_reset();
      run_n(30);
      check($sformatf("rnd%0d_pc", r), int'(pc_dbg), mpc);
      check($sformatf("rnd%0d_pending_out", r), mq.size(), 0);
    end
    rand_en = 1'b0;

    // 8-bit data instance: ADD B,0xFF with B=1 wraps to 0 and sets C
    start = nacc2;
    ok = 1'b0;
    run2 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (nacc2 - start >= 4) begin ok = 1'b1; break; end
    end
    if (!ok) check("dw8_run_timeout", nacc2 - start, 4);
    run2 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (halted2) begin ok = 1'b1; break; end
    end
    if (!ok) check("dw8_halt_timeout", 0, 1);
    check("dw8_pc", int'(pc2), 4);
    check("dw8_out", int'(out2), 0);
    check("dw8_nwe", nwe2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
